// File: rtl/fpdiv_pkg.sv
// Shared types and mux-select encodings for the Goldschmidt fp32 divider.
package fpdiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      IA_N,
      IA_D,
      IT_N,
      IT_D,
      REM_Q,
      REM_R,
      DONE
   } fpdiv_state_t;

   // sel_mux5: multiplier operand pair
   localparam logic [2:0] SEL5_NIA = 3'b000;  // N * IA
   localparam logic [2:0] SEL5_DIA = 3'b001;  // D * IA
   localparam logic [2:0] SEL5_NP  = 3'b010;  // numerator path
   localparam logic [2:0] SEL5_DP  = 3'b011;  // denominator path
   localparam logic [2:0] SEL5_REM = 3'b100;  // mcand_q * D

   // sel_mux3: multiplicand source
   localparam logic [1:0] SEL3_IA  = 2'b00;   // initial approximation
   localparam logic [1:0] SEL3_C   = 2'b01;   // correction factor register
   localparam logic [1:0] SEL3_Q   = 2'b10;   // quotient

endpackage

// File: rtl/fpdiv_seq_ctrl.sv
// Sequencer for the Goldschmidt divider datapath: IA seed pass, N/D
// refinement pairs, then the q*D remainder step, with start/busy/done.
module fpdiv_seq_ctrl
   import fpdiv_pkg::*;
#(
   parameter int unsigned ITERS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rm_in,
   output logic       busy,
   output logic       done,
   output logic       rm,
   output logic       en_a,
   output logic       en_b,
   output logic       en_rem,
   output logic [1:0] sel_mux3,
   output logic [2:0] sel_mux5
);

   localparam int unsigned IW = $clog2(ITERS + 1);
   localparam logic [IW-1:0] ITERS_L = IW'(ITERS);

   fpdiv_state_t state_q, state_d;
   logic [IW-1:0] iter_q, iter_d;
   logic          rm_q, rm_d;

   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       en_a_q, en_a_d;
   logic       en_b_q, en_b_d;
   logic       en_rem_q, en_rem_d;
   logic [1:0] sel3_q, sel3_d;
   logic [2:0] sel5_q, sel5_d;

   // Next-state, iteration count and rounding-mode capture
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      rm_d    = rm_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = IA_N;
               iter_d  = IW'(1);
               rm_d    = rm_in;
            end
         end
         IA_N:  state_d = IA_D;
         IA_D:  state_d = IT_N;
         IT_N:  state_d = IT_D;
         IT_D: begin
            iter_d  = iter_q + 1'b1;
            state_d = (iter_d == ITERS_L) ? REM_Q : IT_N;
         end
         REM_Q: state_d = REM_R;
         REM_R: state_d = DONE;
         DONE:  state_d = IDLE;
         default: begin
            state_d = IDLE;
            iter_d  = '0;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe (Moore behaviour without a cycle lag)
   always_comb begin
      busy_d   = 1'b1;
      done_d   = 1'b0;
      en_a_d   = 1'b0;
      en_b_d   = 1'b0;
      en_rem_d = 1'b0;
      sel3_d   = SEL3_IA;
      sel5_d   = SEL5_NIA;
      case (state_d)
         IA_N: begin
            sel5_d = SEL5_NIA;
            sel3_d = SEL3_IA;
            en_a_d = 1'b1;
         end
         IA_D: begin
            sel5_d = SEL5_DIA;
            sel3_d = SEL3_IA;
            en_b_d = 1'b1;
         end
         IT_N: begin
            sel5_d = SEL5_NP;
            sel3_d = SEL3_C;
            en_a_d = 1'b1;
         end
         IT_D: begin
            sel5_d = SEL5_DP;
            sel3_d = SEL3_C;
            en_b_d = 1'b1;
         end
         REM_Q: begin
            sel5_d   = SEL5_NP;
            sel3_d   = SEL3_Q;
            en_rem_d = 1'b1;
         end
         REM_R: begin
            sel5_d   = SEL5_REM;
            sel3_d   = SEL3_Q;
            en_rem_d = 1'b1;
         end
         DONE: begin
            sel5_d = SEL5_REM;
            sel3_d = SEL3_Q;
            done_d = 1'b1;
         end
         default: busy_d = 1'b0;
      endcase
   end

   // State, counter and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         iter_q   <= '0;
         rm_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         en_a_q   <= 1'b0;
         en_b_q   <= 1'b0;
         en_rem_q <= 1'b0;
         sel3_q   <= SEL3_IA;
         sel5_q   <= SEL5_NIA;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         rm_q     <= rm_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         en_a_q   <= en_a_d;
         en_b_q   <= en_b_d;
         en_rem_q <= en_rem_d;
         sel3_q   <= sel3_d;
         sel5_q   <= sel5_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rm       = rm_q;
   assign en_a     = en_a_q;
   assign en_b     = en_b_q;
   assign en_rem   = en_rem_q;
   assign sel_mux3 = sel3_q;
   assign sel_mux5 = sel5_q;

endmodule
